// File: rtl/mac_accelerator.sv
`default_nettype none
// ============================================================================
// Module      : mac_accelerator
// Description : 4x4-bit multiply-accumulate tile with a 16-bit accumulator,
//               byte-selectable output and sticky overflow status.
//               Optional build macro MAC_SATURATE_EN clamps on overflow.
// Revision    : 1.0 - initial release
// ============================================================================
module mac_accelerator #(
    parameter int ACC_W = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] C,
    output logic [7:0] uio_ou,
    output logic [7:0] uio_oe
);

    localparam logic [7:0] c_uio_oe = 8'hF0;

    logic [ACC_W-1:0] r_acc;
    logic             r_ovf;
    logic             r_valid;

    logic [3:0]        w_op_a;
    logic [3:0]        w_op_b;
    logic              w_acc_en;
    logic              w_clear;
    logic              w_signed_mode;
    logic              w_byte_sel;
    logic [7:0]        w_prod_u;
    logic signed [7:0] w_prod_s;
    logic [ACC_W-1:0]  w_prod;
    logic [ACC_W:0]    w_sum;
    logic              w_ovf_u;
    logic              w_ovf_s;
    logic              w_ovf;
    logic [ACC_W-1:0]  w_next;
    logic              w_zero;
    logic              w_unused_uio;

    assign w_op_a        = ui_in[7:4];
    assign w_op_b        = ui_in[3:0];
    assign w_acc_en      = uio_in[0];
    assign w_clear       = uio_in[1];
    assign w_signed_mode = uio_in[2];
    assign w_byte_sel    = uio_in[3];
    assign w_unused_uio  = &{1'b0, uio_in[7:4]};

    assign w_prod_u = {4'b0000, w_op_a} * {4'b0000, w_op_b};
    assign w_prod_s = $signed({{4{w_op_a[3]}}, w_op_a}) * $signed({{4{w_op_b[3]}}, w_op_b});

    assign w_prod = w_signed_mode ? {{(ACC_W-8){w_prod_s[7]}}, w_prod_s}
                                  : {{(ACC_W-8){1'b0}}, w_prod_u};

    assign w_sum = {1'b0, r_acc} + {1'b0, w_prod};

    // Signed overflow: like-signed operands producing a result of the other sign.
    assign w_ovf_u = w_sum[ACC_W];
    assign w_ovf_s = (r_acc[ACC_W-1] == w_prod[ACC_W-1]) &&
                     (w_sum[ACC_W-1] != r_acc[ACC_W-1]);
    assign w_ovf   = w_signed_mode ? w_ovf_s : w_ovf_u;

`ifdef MAC_SATURATE_EN
    always_comb begin
        w_next = w_sum[ACC_W-1:0];
        if (w_ovf) begin
            if (!w_signed_mode)
                w_next = {ACC_W{1'b1}};
            else if (r_acc[ACC_W-1])
                w_next = {1'b1, {(ACC_W-1){1'b0}}};
            else
                w_next = {1'b0, {(ACC_W-1){1'b1}}};
        end
    end
`else
    assign w_next = w_sum[ACC_W-1:0];
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_acc   <= '0;
            r_ovf   <= 1'b0;
            r_valid <= 1'b0;
        end else if (ena) begin
            if (w_clear) begin
                r_acc   <= '0;
                r_ovf   <= 1'b0;
                r_valid <= 1'b0;
            end else if (w_acc_en) begin
                r_acc   <= w_next;
                r_ovf   <= r_ovf | w_ovf;
                r_valid <= 1'b1;
            end else begin
                r_valid <= 1'b0;
            end
        end
    end

    assign w_zero = (r_acc == '0);
    assign C      = w_byte_sel ? r_acc[ACC_W-1:ACC_W-8] : r_acc[7:0];
    assign uio_ou = {r_valid, r_acc[ACC_W-1], w_zero, r_ovf, 4'b0000};
    assign uio_oe = c_uio_oe;

endmodule
`default_nettype wire

// File: tb/tb_mac_accelerator.sv
`default_nettype none
// ============================================================================
// Module      : tb_mac_accelerator
// Description : Self-checking bench for mac_accelerator (wrap and saturate builds).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mac_accelerator;

    logic       clk = 1'b0;
    logic       rst;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] C;
    logic [7:0] uio_ou;
    logic [7:0] uio_oe;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state, kept as plain integers
    int m_acc   = 0;
    bit m_ovf   = 0;
    bit m_valid = 0;

    typedef struct {
        logic       ena;
        logic [7:0] ui;
        logic [7:0] uio;
        logic [7:0] exp_c;
        logic [7:0] exp_ou;
    } vec_t;

    vec_t vecs[12];

    mac_accelerator #(.ACC_W(16)) dut (
        .clk    (clk),
        .rst    (rst),
        .ena    (ena),
        .ui_in  (ui_in),
        .uio_in (uio_in),
        .C      (C),
        .uio_ou (uio_ou),
        .uio_oe (uio_oe)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    function automatic int to_s4(input int v);
        return (v >= 8) ? v - 16 : v;
    endfunction

    // Model update from the arithmetic rules: overflow means out of representable range.
    task automatic model_edge(input bit r, input bit e, input logic [7:0] ui, input logic [7:0] uio);
        int a, b, s;
        bit ov;
        if (!r) begin
            m_acc = 0; m_ovf = 0; m_valid = 0;
        end else if (e) begin
            if (uio[1]) begin
                m_acc = 0; m_ovf = 0; m_valid = 0;
            end else if (uio[0]) begin
                a = ui[7:4];
                b = ui[3:0];
                if (uio[2]) begin
                    s  = ((m_acc >= 32768) ? m_acc - 65536 : m_acc) + to_s4(a) * to_s4(b);
                    ov = (s > 32767) || (s < -32768);
`ifdef MAC_SATURATE_EN
                    if (s > 32767)  s = 32767;
                    if (s < -32768) s = -32768;
`endif
                end else begin
                    s  = m_acc + a * b;
                    ov = (s > 65535);
`ifdef MAC_SATURATE_EN
                    if (s > 65535) s = 65535;
`endif
                end
                m_acc   = s & 32'h0000FFFF;
                m_ovf   = m_ovf | ov;
                m_valid = 1;
            end else begin
                m_valid = 0;
            end
        end
    endtask

    // Apply one cycle of inputs; outputs are sampled 1 time unit after the edge.
    task automatic step(input bit r, input bit e, input logic [7:0] ui, input logic [7:0] uio);
        rst = r; ena = e; ui_in = ui; uio_in = uio;
        @(posedge clk);
        model_edge(r, e, ui, uio);
        #1;
    endtask

    task automatic check_model(input string name);
        logic [15:0] acc16;
        logic [7:0]  exp_c;
        logic [7:0]  exp_ou;
        acc16  = m_acc[15:0];
        exp_c  = uio_in[3] ? acc16[15:8] : acc16[7:0];
        exp_ou = {m_valid, acc16[15], (m_acc == 0), m_ovf, 4'b0000};
        check({name, ".C"}, C, exp_c);
        check({name, ".uio_ou"}, uio_ou, exp_ou);
    endtask

    initial begin
        vecs[0]  = '{1'b1, 8'h35, 8'h01, 8'h0F, 8'h80};
        vecs[1]  = '{1'b1, 8'h35, 8'h01, 8'h1E, 8'h80};
        vecs[2]  = '{1'b1, 8'h35, 8'h01, 8'h2D, 8'h80};
        vecs[3]  = '{1'b1, 8'h35, 8'h00, 8'h2D, 8'h00};
        vecs[4]  = '{1'b1, 8'h35, 8'h02, 8'h00, 8'h20};
        vecs[5]  = '{1'b1, 8'hF3, 8'h05, 8'hFD, 8'hC0};
        vecs[6]  = '{1'b1, 8'hF3, 8'h08, 8'hFF, 8'h40};
        vecs[7]  = '{1'b1, 8'h35, 8'h03, 8'h00, 8'h20};
        vecs[8]  = '{1'b1, 8'h35, 8'h01, 8'h0F, 8'h80};
        vecs[9]  = '{1'b0, 8'h35, 8'h01, 8'h0F, 8'h80};
        vecs[10] = '{1'b0, 8'hFF, 8'h03, 8'h0F, 8'h80};
        vecs[11] = '{1'b1, 8'h35, 8'h00, 8'h0F, 8'h00};

        rst = 1'b0; ena = 1'b1; ui_in = 8'h00; uio_in = 8'h00;
        step(1'b0, 1'b1, 8'hAA, 8'h0F);
        check("oe_in_reset", uio_oe, 8'hF0);
        step(1'b0, 1'b1, 8'h00, 8'h00);
        step(1'b1, 1'b1, 8'h00, 8'h00);
        check("reset.C", C, 8'h00);
        check("reset.uio_ou", uio_ou, 8'h20);
        check("reset.uio_oe", uio_oe, 8'hF0);

        for (int i = 0; i < 12; i++) begin
            step(1'b1, vecs[i].ena, vecs[i].ui, vecs[i].uio);
            check($sformatf("vec%0d.C", i), C, vecs[i].exp_c);
            check($sformatf("vec%0d.uio_ou", i), uio_ou, vecs[i].exp_ou);
        end

        // Unsigned overflow over 292 accumulates of 15*15
        step(1'b1, 1'b1, 8'h00, 8'h02);
        for (int i = 0; i < 292; i++) step(1'b1, 1'b1, 8'hFF, 8'h01);
`ifdef MAC_SATURATE_EN
        check("ovf_u.C_lo", C, 8'hFF);
        step(1'b1, 1'b1, 8'hFF, 8'h08);
        check("ovf_u.C_hi", C, 8'hFF);
`else
        check("ovf_u.C_lo", C, 8'hA4);
        step(1'b1, 1'b1, 8'hFF, 8'h08);
        check("ovf_u.C_hi", C, 8'h00);
`endif
        check("ovf_u.flag", uio_ou & 8'h10, 8'h10);
        step(1'b1, 1'b1, 8'h11, 8'h01);
        check("ovf_u.sticky", uio_ou & 8'h10, 8'h10);
        check_model("ovf_u.model");

        // Signed positive then negative overflow
        step(1'b1, 1'b1, 8'h00, 8'h02);
        for (int i = 0; i < 700; i++) step(1'b1, 1'b1, 8'h77, 8'h05);
        check("ovf_sp.flag", uio_ou & 8'h10, 8'h10);
        check_model("ovf_sp");
        step(1'b1, 1'b1, 8'h77, 8'h0D);
        check_model("ovf_sp_hi");
        step(1'b1, 1'b1, 8'h00, 8'h02);
        check("clear.ovf", uio_ou, 8'h20);
        for (int i = 0; i < 600; i++) step(1'b1, 1'b1, 8'h87, 8'h05);
        check("ovf_sn.flag", uio_ou & 8'h10, 8'h10);
        check_model("ovf_sn");
        step(1'b1, 1'b1, 8'h87, 8'h0C);
        check_model("ovf_sn_hi");

        // Mid-run reset while accumulating
        step(1'b1, 1'b1, 8'h23, 8'h01);
        step(1'b0, 1'b1, 8'h23, 8'h01);
        check("midrst.C", C, 8'h00);
        check("midrst.uio_ou", uio_ou, 8'h20);
        check("midrst.uio_oe", uio_oe, 8'hF0);

        // Randomized traffic against the reference model
        for (int i = 0; i < 1500; i++) begin
            logic [7:0] u;
            bit r, e;
            u = 8'($urandom) & 8'h0D;
            if ($urandom_range(0, 19) == 0) u[1] = 1'b1;
            if ($urandom_range(0, 3) != 0) u[0] = 1'b1;
            u[7:4] = 4'($urandom);
            r = ($urandom_range(0, 99) != 0);
            e = ($urandom_range(0, 9) != 0);
            step(r, e, 8'($urandom), u);
            check_model($sformatf("rand%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
